ifetch_queue: RTL and testbench

- Instruction fetch stage directly upstream of the CPU datapath.
- Generates sequential fetch addresses and issues them to instruction memory over a valid/ready request channel.
- Collects in-order responses into a small instruction queue and presents instr plus its pc to the datapath with a valid/ready handshake.
- Supports redirect (branch/jump/trap): flushes the queue and discards in-flight stale responses.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 84 ++++++++
 rtl/ifetch_queue.sv | 154 +++++++++++++++
 tb/tb_ifetch_queue.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-front-end types: fetch queue entry, fetch FSM states and PC helpers.
package cpu_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_DRAIN = 1'b1
  } fetch_state_e;

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES) - XLEN'(1));

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with registered storage, simultaneous push/pop
// (also when full) and a single-cycle flush that overrides push and pop.
module sync_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push_s = push_i & (~full_o | pop_i) & ~flush_i;
  assign do_pop_s  = pop_i & ~empty_o & ~flush_i;
  assign head_o    = mem_q[rptr_q];
  assign count_o   = count_q;

  // Pointer and occupancy next-state
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push_s) begin
        wptr_d = wptr_q + AW'(1);
      end else begin
        wptr_d = wptr_q;
      end
      if (do_pop_s) begin
        rptr_d = rptr_q + AW'(1);
      end else begin
        rptr_d = rptr_q;
      end
      count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; cleared on reset so an empty queue never exposes X
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: sequential request generation with credit-limited
// issue, in-order response queueing, and redirect with stale-response draining.
module ifetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned     DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            run_en_q;

  fetch_entry_t    push_entry_s;
  fetch_entry_t    head_s;
  logic [CW-1:0]   fifo_count_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;

  logic            credit_ok_s;
  logic            req_valid_s;
  logic            req_fire_s;
  logic            dropping_s;
  logic            rsp_push_s;
  logic            pop_s;

  // Credit counts queued entries plus everything outstanding, stale or not.
  assign credit_ok_s  = ~fifo_full_s &
                        (({1'b0, fifo_count_s} + {1'b0, inflight_q}) < DEPTH_C);
  assign req_valid_s  = run_en_q & ~redirect & credit_ok_s;
  assign req_fire_s   = req_valid_s & imem_req_ready;
  assign dropping_s   = (state_q == FETCH_DRAIN);
  assign rsp_push_s   = imem_rsp_valid & ~dropping_s & ~redirect;
  assign pop_s        = ~fifo_empty_s & instr_ready & ~redirect;
  assign push_entry_s = '{instr: imem_rsp_data, pc: rsp_pc_q};

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (rsp_push_s),
    .pop_i   (pop_s),
    .flush_i (redirect),
    .data_i  (push_entry_s),
    .head_o  (head_s),
    .count_o (fifo_count_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // PC, in-flight and drop counter next-state
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_cnt_d = drop_cnt_q;
    inflight_d = inflight_q + CW'(req_fire_s) - CW'(imem_rsp_valid);
    if (redirect) begin
      fetch_pc_d = word_align(redirect_pc);
      rsp_pc_d   = word_align(redirect_pc);
      drop_cnt_d = inflight_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire_s) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (imem_rsp_valid && dropping_s) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end else if (rsp_push_s) begin
        rsp_pc_d = rsp_pc_q + PC_STEP;
      end else begin
        drop_cnt_d = drop_cnt_q;
        rsp_pc_d   = rsp_pc_q;
      end
    end
  end

  // Fetch FSM next-state: DRAIN while stale responses remain to be discarded
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_RUN: begin
        if (redirect && (drop_cnt_d != '0)) begin
          state_d = FETCH_DRAIN;
        end else begin
          state_d = FETCH_RUN;
        end
      end
      FETCH_DRAIN: begin
        if (drop_cnt_d == '0) begin
          state_d = FETCH_RUN;
        end else begin
          state_d = FETCH_DRAIN;
        end
      end
      default: state_d = FETCH_RUN;
    endcase
  end

  // Fetch FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Address and counter registers; run_en_q holds requests off while in reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      run_en_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      run_en_q   <= 1'b1;
    end
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fetch_pc_q;
  assign instr_valid    = ~fifo_empty_s;
  assign instr          = fifo_empty_s ? '0 : head_s.instr;
  assign instr_pc       = fifo_empty_s ? '0 : head_s.pc;

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized scoreboard bench for ifetch_queue: a memory model answers requests
// in order; the expected instruction stream is the sequential PC walk from the
// last reset/redirect target.
module tb_ifetch_queue;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk, rst;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        redirect, instr_valid, instr_ready;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, instr, instr_pc;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } exp_t;

  mreq_t mem_q[$];
  exp_t  exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, last_due = 0, lat = 1, rdy_pct = 100, irdy_pct = 100;
  logic [31:0] exp_fetch, exp_next, redir_target;
  bit redir_now, redir_on_busy, busy_hit;
  bit s_hs, s_reqv, s_ivalid, hs_seen, pop_seen;
  logic [31:0] s_hs_addr, s_ipc, first_hs_addr, first_pop_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", name, got, exp);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{instr: mem_word(exp_next), pc: exp_next});
      exp_next += 32'd4;
    end
  endtask

  task automatic restart_model(input logic [31:0] pc);
    exp_q.delete();
    exp_next  = pc;
    exp_fetch = pc;
    refill();
  endtask

  // One clock cycle: drive at negedge, observe and update the model 1 time unit later.
  task automatic step();
    int due;
    @(negedge clk);
    imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
    instr_ready    = ($urandom_range(0, 99) < irdy_pct);
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    redirect    = redir_now;
    redirect_pc = redir_target;
    redir_now   = 1'b0;
    if (redir_on_busy && imem_rsp_valid && instr_valid && instr_ready) begin
      redirect      = 1'b1;
      redir_on_busy = 1'b0;
      busy_hit      = 1'b1;
    end
    #1;
    s_reqv    = imem_req_valid;
    s_ivalid  = instr_valid;
    s_ipc     = instr_pc;
    s_hs      = imem_req_valid && imem_req_ready;
    s_hs_addr = imem_req_addr;
    if (redirect) begin
      chk_b("no_req_on_redirect", imem_req_valid, 1'b0);
      restart_model(redirect_pc & 32'hFFFF_FFFC);
      hs_seen  = 1'b0;
      pop_seen = 1'b0;
    end else begin
      if (s_hs) begin
        chk("req_addr", imem_req_addr, exp_fetch);
        exp_fetch += 32'd4;
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        last_due = due;
        mem_q.push_back('{addr: imem_req_addr, due: due});
        if (!hs_seen) begin
          hs_seen = 1'b1;
          first_hs_addr = imem_req_addr;
        end
      end
      if (instr_valid && instr_ready && !pop_seen) begin
        pop_seen = 1'b1;
        first_pop_pc = instr_pc;
      end
    end
    refill();
    cyc++;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_b("rst_req_valid", imem_req_valid, 1'b0);
    chk_b("rst_instr_valid", instr_valid, 1'b0);
    mem_q.delete();
    last_due       = 0;
    imem_rsp_valid = 1'b0;
    redirect       = 1'b0;
    restart_model(RESET_PC);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_until_seen(input string name);
    for (int i = 0; i < 40 && !(hs_seen && pop_seen); i++) step();
    chk_b(name, hs_seen && pop_seen, 1'b1);
  endtask

  initial begin
    int n, hs_cyc, v_cyc;
    rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    redir_now = 1'b0; redir_on_busy = 1'b0; busy_hit = 1'b0; redir_target = '0;
    hs_seen = 1'b0; pop_seen = 1'b0;
    restart_model(RESET_PC);

    fork
      forever begin : monitor
        exp_t e;
        @(negedge clk);
        #2;
        if (rst && instr_valid && instr_ready && !redirect) begin
          if (exp_q.size() == 0) begin
            chk_b("scoreboard_underflow", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            chk("instr_pc", instr_pc, e.pc);
            chk("instr", instr, e.instr);
          end
        end
      end
    join_none

    // Reset values
    #2;
    chk_b("reset_req_valid", imem_req_valid, 1'b0);
    chk_b("reset_instr_valid", instr_valid, 1'b0);
    chk("reset_instr", instr, 32'h0);
    chk("reset_instr_pc", instr_pc, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Consumer stalled: exactly DEPTH requests, queue holds 0x0 and 0x4
    lat = 1; rdy_pct = 100; irdy_pct = 0; n = 0;
    repeat (10) begin step(); if (s_hs) n++; end
    chk("stall_req_count", 32'(n), 32'd2);
    chk_b("stall_req_valid", s_reqv, 1'b0);
    chk_b("stall_instr_valid", s_ivalid, 1'b1);
    chk("stall_head_pc", s_ipc, 32'h0);

    // Resume: fetch continues at 0x8
    irdy_pct = 100; hs_seen = 1'b0; pop_seen = 1'b0;
    run_until_seen("resume_timeout");
    chk("resume_addr", first_hs_addr, 32'h8);
    repeat (6) step();

    // Fill the queue again, then reset asynchronously mid-cycle
    irdy_pct = 0;
    repeat (8) step();
    chk_b("full_req_valid", s_reqv, 1'b0);
    chk_b("full_instr_valid", s_ivalid, 1'b1);
    apply_reset();

    // Streaming from reset: restart at RESET_PC, first instr 2 cycles after handshake
    irdy_pct = 100; hs_cyc = -1; v_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_hs && hs_cyc < 0) begin
        hs_cyc = cyc - 1;
        chk("restart_addr", s_hs_addr, RESET_PC);
      end
      if (v_cyc >= 0 && cyc - 1 == v_cyc + 1) begin
        chk_b("second_valid", s_ivalid, 1'b1);
        chk("second_pc", s_ipc, 32'h4);
      end
      if (s_ivalid && v_cyc < 0) begin
        v_cyc = cyc - 1;
        chk("first_pc", s_ipc, 32'h0);
      end
    end
    chk("startup_latency", 32'(v_cyc - hs_cyc), 32'd2);

    // 3-cycle memory, two stale requests in flight, redirect to 0x100
    apply_reset();
    lat = 3; irdy_pct = 0; n = 0;
    for (int i = 0; i < 10 && n < 2; i++) begin step(); if (s_hs) n++; end
    chk("inflight_before_redirect", 32'(n), 32'd2);
    irdy_pct = 100; redir_target = 32'h100; redir_now = 1'b1;
    step();
    run_until_seen("drain_timeout");
    chk("drain_first_req", first_hs_addr, 32'h100);
    chk("drain_first_pc", first_pop_pc, 32'h100);

    // Redirect coinciding with a response and a pop, unaligned target
    lat = 1; busy_hit = 1'b0; redir_target = 32'h203; redir_on_busy = 1'b1;
    for (int i = 0; i < 20 && !busy_hit; i++) step();
    chk_b("busy_redirect_hit", busy_hit, 1'b1);
    redir_on_busy = 1'b0;
    step();
    chk_b("flush_instr_valid", s_ivalid, 1'b0);
    run_until_seen("busy_timeout");
    chk("busy_first_req", first_hs_addr, 32'h200);
    chk("busy_first_pc", first_pop_pc, 32'h200);

    // Back-to-back redirects: only the second target is fetched
    redir_target = 32'h40; redir_now = 1'b1; step();
    redir_target = 32'h80; redir_now = 1'b1; step();
    run_until_seen("b2b_timeout");
    chk("b2b_first_req", first_hs_addr, 32'h80);
    chk("b2b_first_pc", first_pop_pc, 32'h80);

    // Address wrap at the top of the space
    redir_target = 32'hFFFF_FFF8; redir_now = 1'b1;
    repeat (16) step();

    // Randomized traffic
    rdy_pct = 70; irdy_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) lat = $urandom_range(1, 4);
      if ($urandom_range(0, 39) == 0) begin
        redir_now    = 1'b1;
        redir_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                    : $urandom;
      end
      step();
    end
    rdy_pct = 100; irdy_pct = 100;
    repeat (30) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
